// File: rtl/picosoc_bus_pkg.sv
// Shared types and constants for the picosoc bus arbiter.
// The optional watchdog is enabled by PICOSOC_ARB_TIMEOUT_EN.
package picosoc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/picosoc_arb_watchdog.sv
// Stall counter for the arbiter grant.
// Expires when the count reaches LIMIT; used with PICOSOC_ARB_TIMEOUT_EN.
module picosoc_arb_watchdog #(
  parameter int LIMIT = 255,
  localparam int CW = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CW-1:0] cnt_q;

  assign expired_o = (cnt_q == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/picosoc_mem_arbiter.sv
// Two-master round-robin arbiter on the picorv32 valid/ready bus.
// Define PICOSOC_ARB_TIMEOUT_EN to add the grant watchdog.
module picosoc_mem_arbiter
  import picosoc_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        owner,
  output logic              timeout_err
);

  arb_state_e state_q;
  logic       rr_last_q;
  logic       expire;
  logic       done;
  logic       own_valid;
  logic [DATA_W-1:0] grant_rdata;

  assign owner       = state_q;
  assign own_valid   = (state_q == GRANT1) ? m1_valid : m0_valid;
  assign done        = (s_valid & s_ready) | expire;
  assign grant_rdata = expire ? DATA_W'(ARB_ERR_DATA) : s_rdata;

`ifdef PICOSOC_ARB_TIMEOUT_EN
  logic wd_exp;
  logic toe_q;

  picosoc_arb_watchdog #(
    .LIMIT(TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == IDLE),
    .en_i     (!s_ready),
    .expired_o(wd_exp)
  );

  assign expire      = wd_exp & (state_q != IDLE);
  assign timeout_err = toe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      toe_q <= 1'b0;
    end else if (expire) begin
      toe_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT;
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    unique case (state_q)
      GRANT0: begin
        s_valid  = m0_valid & ~expire;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready | expire;
        m0_rdata = grant_rdata;
      end
      GRANT1: begin
        s_valid  = m1_valid & ~expire;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready | expire;
        m1_rdata = grant_rdata;
      end
      default: ;
    endcase
  end

  // rr_last_q names the master served last; the other wins contention
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= M1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m0_valid && (!m1_valid || rr_last_q == M1)) begin
            state_q <= GRANT0;
          end else if (m1_valid) begin
            state_q <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (done) begin
            state_q   <= IDLE;
            rr_last_q <= (state_q == GRANT1) ? M1 : M0;
          end else if (!own_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/picosoc_mem_arbiter.md
# picosoc_mem_arbiter

Two-master round-robin arbiter sharing the single on-chip memory/peripheral bus of the synchronous picocpu system between the CPU and a second bus master (debug loader / DMA). It uses the picorv32 native valid/ready memory protocol on all ports. It locks a grant for the duration of one transaction and forwards it unchanged to the shared slave. It sits between `picorv32` and the memory/GPIO decode inside `system`.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`
- `TIMEOUT`, 255, watchdog limit in cycles; only used with `PICOSOC_ARB_TIMEOUT_EN`

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `m0_valid`  in  1  CPU request
- `m0_addr`  in  ADDR_W  CPU address
- `m0_wdata`  in  DATA_W  CPU write data
- `m0_wstrb`  in  DATA_W/8  CPU byte strobes; 0 = read
- `m0_ready`  out  1  CPU transaction complete
- `m0_rdata`  out  DATA_W  CPU read data
- `m1_valid`, `m1_addr`, `m1_wdata`, `m1_wstrb`, `m1_ready`, `m1_rdata`: same as m0, second master
- `s_valid`  out  1  shared-slave request
- `s_addr`, `s_wdata`, `s_wstrb`  out  ADDR_W / DATA_W / DATA_W/8  forwarded from owner
- `s_ready`  in  1  slave completion
- `s_rdata`  in  DATA_W  slave read data
- `owner`  out  2  one-hot current grant: 01 = m0, 10 = m1, 00 = idle
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, GRANT0, GRANT1. State is registered. `owner` decodes the state directly.
- IDLE:
  - only m0_valid → GRANT0; only m1_valid → GRANT1.
  - both valid → grant the master that was not served last (`rr_last` register).
  - none valid → stay in IDLE.
- GRANTx, forwarding:
  - `s_valid = mx_valid`; `s_addr/s_wdata/s_wstrb` = mx fields (combinational mux selected by state).
  - `mx_ready = s_ready`; `mx_rdata = s_rdata`.
  - Non-owner: `ready` = 0, `rdata` = 0.
- GRANTx, release:
  - `s_valid & s_ready` → IDLE next cycle; `rr_last <= x`.
  - Owner drops `mx_valid` before ready (protocol abandon) → IDLE next cycle; `rr_last` is not updated.
- In IDLE, all `s_*` outputs are 0 and both `mx_ready` are 0.
- Requests arriving during a grant wait. A master must hold valid and its fields stable until its ready.

## Timing
- Grant latency: mx_valid sampled high in IDLE at edge N → `s_valid` high from cycle N+1.
- Completion is combinational pass-through: mx_ready rises in the same cycle as s_ready.
- One mandatory IDLE bubble after every transaction. Minimum transaction period = slave latency + 2 cycles.
- Reset values: state IDLE, `rr_last` = 1 (m0 wins the first contention), `owner` = 00, `s_valid` = 0, both `mx_ready` = 0, both `mx_rdata` = 0, `timeout_err` = 0, watchdog counter = 0.
- Reset asserted mid-transaction: IDLE on the next edge. `s_valid` drops in that cycle. The in-flight transaction is not completed to the master.
- Simultaneous events:
  - s_ready in the same cycle the other master raises valid → the other master is granted on the next edge after the bubble, i.e. it is sampled in IDLE.
  - Continuous requests from both masters strictly alternate.

## Configuration
- `PICOSOC_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to GRANTx and increments each cycle `s_ready` is low.
  - When the counter equals `TIMEOUT`: owner's `mx_ready` = 1 and `mx_rdata` = 32'hDEADBEEF for that one cycle, `s_valid` forced 0, `timeout_err` set (sticky until reset), state → IDLE, `rr_last` updated.
  - Counter width is `$clog2(TIMEOUT+1)`.
- Undefined: no counter; a grant waits indefinitely for `s_ready`; `timeout_err` tied 0.

## Structure
- Shared package `picosoc_bus_pkg`:
  - state enum (IDLE/GRANT0/GRANT1)
  - `ARB_ERR_DATA` = 32'hDEADBEEF
  - master index constants
- Sub-module `picosoc_arb_watchdog`: counter plus expiry pulse with clear/enable inputs. Instantiated only under the macro.

## Test plan
- After reset, m0 read of addr 0x100, slave ready after 2 cycles with rdata 0x12345678 → s_valid at N+1, m0_ready high 3 cycles after request, m0_rdata = 0x12345678, owner 01 → 00.
- m0 and m1 both raise valid in the same cycle → m0 granted first; m1 granted after m0 completes plus one IDLE cycle.
- Both masters held valid for 6 transactions, slave ready immediately → owner sequence 01,00,10,00,01,00,...; each transaction takes 2 cycles.
- m1 write wdata 0xA5A5A5A5, wstrb 0x3, while m0 idle → s_wdata/s_wstrb match exactly; m0_ready and m0_rdata stay 0 throughout.
- reset pulsed while in GRANT1 with the slave stalled → next cycle owner = 00, s_valid = 0, m1_ready never asserted.
- With the macro, TIMEOUT = 4 and a slave that never readies → m0_ready pulses once with 0xDEADBEEF 4 cycles after the grant, and timeout_err stays 1. Without the macro, the same stimulus → no ready and timeout_err = 0.
